// File: rtl/sound_i2s_rx.sv
// sound_i2s_rx
//   I2S receiver. Oversamples asynchronous sclk/lrck/data pins on clk_74a and
//   delivers one registered left/right pair per frame with a single-cycle strobe.
//   Stream format: 64 sclk per frame, 32-bit slots, MSB first, data delayed
//   one sclk after each lrck edge. lrck low = left, lrck high = right.
//
// Parameters
//   CHANNEL_WIDTH  bits kept per channel, from the MSB end of each slot (1..16)
//
// Ports
//   clk_74a       in   system clock (74.25 MHz)
//   reset         in   synchronous, active-high
//   i2s_sclk      in   serial bit clock, asynchronous
//   i2s_lrck      in   word select, asynchronous
//   i2s_data      in   serial data, asynchronous
//   audio_l       out  last complete left sample
//   audio_r       out  last complete right sample
//   sample_valid  out  1-cycle pulse when audio_l/audio_r update
//   frame_err     out  1-cycle pulse on a malformed slot (checked build only)
//
// Configuration
//   I2S_RX_FRAME_CHECK_EN  when defined, every boundary checks the slot held
//                          32 sclk rises; a mismatch pulses frame_err, drops
//                          the pair and forces a resync. Undefined: no check,
//                          frame_err is constant 0.

module sound_i2s_rx #(
    parameter int CHANNEL_WIDTH = 16
) (
    input  logic                     clk_74a,
    input  logic                     reset,
    input  logic                     i2s_sclk,
    input  logic                     i2s_lrck,
    input  logic                     i2s_data,
    output logic [CHANNEL_WIDTH-1:0] audio_l,
    output logic [CHANNEL_WIDTH-1:0] audio_r,
    output logic                     sample_valid,
    output logic                     frame_err
);

    // 2-FF synchronisers plus one history FF per pin
    logic r_sclk_s1, r_sclk_s2, r_sclk_h;
    logic r_lrck_s1, r_lrck_s2, r_lrck_h;
    logic r_data_s1, r_data_s2, r_data_h;

    // Registered rise strobe; r_lrck_h / r_data_h are aligned with it
    logic r_rise;

    logic                     r_have_lr;   // lrck reference captured since reset
    logic                     r_lrck_prev; // lrck at previous decoded rise
    logic                     r_seen_bnd;  // a real boundary seen: next slot is whole
    logic                     r_synced;    // a whole left slot is in r_left_hold
    logic [5:0]               r_bit_cnt;
    logic [CHANNEL_WIDTH-1:0] r_shift;
    logic [CHANNEL_WIDTH-1:0] r_left_hold;
    logic [CHANNEL_WIDTH-1:0] r_audio_l;
    logic [CHANNEL_WIDTH-1:0] r_audio_r;
    logic                     r_valid;
    logic                     r_ferr;

    logic                     w_boundary;
    logic                     w_len_err;
    logic [CHANNEL_WIDTH:0]   w_shift_ext;
    logic [CHANNEL_WIDTH-1:0] w_shift_nx;

    assign w_boundary  = r_lrck_h != r_lrck_prev;
    // Wide concatenation keeps the shift legal for CHANNEL_WIDTH == 1
    assign w_shift_ext = {r_shift, r_data_h};
    assign w_shift_nx  = w_shift_ext[CHANNEL_WIDTH-1:0];

`ifdef I2S_RX_FRAME_CHECK_EN
    // The first boundary after reset/resync closes a partial slot, so it is not judged
    assign w_len_err = r_seen_bnd && (r_bit_cnt != 6'd31);
`else
    assign w_len_err = 1'b0;
`endif

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            r_sclk_s1   <= 1'b0;
            r_sclk_s2   <= 1'b0;
            r_sclk_h    <= 1'b0;
            r_lrck_s1   <= 1'b0;
            r_lrck_s2   <= 1'b0;
            r_lrck_h    <= 1'b0;
            r_data_s1   <= 1'b0;
            r_data_s2   <= 1'b0;
            r_data_h    <= 1'b0;
            r_rise      <= 1'b0;
            r_have_lr   <= 1'b0;
            r_lrck_prev <= 1'b0;
            r_seen_bnd  <= 1'b0;
            r_synced    <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_left_hold <= '0;
            r_audio_l   <= '0;
            r_audio_r   <= '0;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_sclk_s1 <= i2s_sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_h  <= r_sclk_s2;
            r_lrck_s1 <= i2s_lrck;
            r_lrck_s2 <= r_lrck_s1;
            r_lrck_h  <= r_lrck_s2;
            r_data_s1 <= i2s_data;
            r_data_s2 <= r_data_s1;
            r_data_h  <= r_data_s2;
            r_rise    <= r_sclk_s2 & ~r_sclk_h;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;

            if (r_rise) begin
                if (!r_have_lr) begin
                    // First rise after reset only establishes the lrck reference,
                    // so a reset while lrck is high does not fake a boundary.
                    r_have_lr   <= 1'b1;
                    r_lrck_prev <= r_lrck_h;
                end else if (w_boundary) begin
                    // Bit sampled here is the previous slot's LSB: dropped.
                    r_lrck_prev <= r_lrck_h;
                    r_bit_cnt   <= '0;
                    r_seen_bnd  <= 1'b1;
                    if (w_len_err) begin
                        r_synced <= 1'b0;
                        r_ferr   <= 1'b1;
                    end else if (r_lrck_h) begin
                        // Left done; it is whole only if it began at a boundary
                        r_left_hold <= r_shift;
                        r_synced    <= r_seen_bnd;
                    end else if (r_synced) begin
                        r_audio_l <= r_left_hold;
                        r_audio_r <= r_shift;
                        r_valid   <= 1'b1;
                    end
                end else begin
                    if (r_bit_cnt < 6'(CHANNEL_WIDTH))
                        r_shift <= w_shift_nx;
                    if (r_bit_cnt != 6'd63)
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                end
            end
        end
    end

    assign audio_l      = r_audio_l;
    assign audio_r      = r_audio_r;
    assign sample_valid = r_valid;
    assign frame_err    = r_ferr;

endmodule

// File: tb/tb_sound_i2s_rx.sv
`timescale 1ns/1ps
module tb_sound_i2s_rx;

`ifdef I2S_RX_FRAME_CHECK_EN
    localparam bit FCHK = 1'b1;
`else
    localparam bit FCHK = 1'b0;
`endif
    localparam int H3 = 163; // ~3.072 MHz sclk half period
    localparam int H6 = 81;  // ~6.144 MHz sclk half period

    logic clk = 1'b0;
    logic reset;
    logic i2s_sclk, i2s_lrck, i2s_data;
    logic [15:0] a16_l, a16_r;
    logic [14:0] a15_l, a15_r;
    logic sv16, sv15, fe16, fe15;

    always #6.734 clk = ~clk;

    sound_i2s_rx #(.CHANNEL_WIDTH(16)) dut16 (
        .clk_74a(clk), .reset(reset), .i2s_sclk(i2s_sclk), .i2s_lrck(i2s_lrck),
        .i2s_data(i2s_data), .audio_l(a16_l), .audio_r(a16_r),
        .sample_valid(sv16), .frame_err(fe16));

    sound_i2s_rx #(.CHANNEL_WIDTH(15)) dut15 (
        .clk_74a(clk), .reset(reset), .i2s_sclk(i2s_sclk), .i2s_lrck(i2s_lrck),
        .i2s_data(i2s_data), .audio_l(a15_l), .audio_r(a15_r),
        .sample_valid(sv15), .frame_err(fe15));

    int checks = 0;
    int failures = 0;
    int npulse16 = 0;
    int nferr16 = 0;
    int nferr15 = 0;
    logic [31:0] q16[$];
    logic [29:0] q15[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT strobes a pair
    always @(negedge clk) begin
        if (sv16) begin
            npulse16++;
            checks++;
            if (q16.size() == 0) begin
                failures++;
                $display("FAIL sv16_unexpected got l=%h r=%h want none", a16_l, a16_r);
            end else begin
                logic [31:0] e;
                e = q16.pop_front();
                if ({a16_l, a16_r} !== e) begin
                    failures++;
                    $display("FAIL pair16 got l=%h r=%h want l=%h r=%h", a16_l, a16_r, e[31:16], e[15:0]);
                end
            end
        end
        if (sv15) begin
            checks++;
            if (q15.size() == 0) begin
                failures++;
                $display("FAIL sv15_unexpected got l=%h r=%h want none", a15_l, a15_r);
            end else begin
                logic [29:0] e;
                e = q15.pop_front();
                if ({a15_l, a15_r} !== e) begin
                    failures++;
                    $display("FAIL pair15 got l=%h r=%h want l=%h r=%h", a15_l, a15_r, e[29:15], e[14:0]);
                end
            end
        end
        if (fe16) nferr16++;
        if (fe15) nferr15++;
    end

    // One slot of n sclk periods; word sits in the top 16 bits, one-bit delay after lrck
    task automatic send_slot(input logic lr, input logic [15:0] w, input int n,
                             input int half, input int rst_at);
        for (int i = 0; i < n; i++) begin
            i2s_sclk = 1'b0;
            if (i == 0) i2s_lrck = lr;
            i2s_data = (i >= 1 && i <= 16) ? w[16-i] : 1'b0;
            if (i == rst_at) begin
                @(negedge clk);
                reset = 1'b1;
                repeat (5) @(negedge clk);
                chk("rst_mid_sv", {31'd0, sv16}, 32'd0);
                chk("rst_mid_audio", {a16_l, a16_r}, 32'd0);
                reset = 1'b0;
            end
            #(half);
            i2s_sclk = 1'b1;
            #(half);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nleft,
                              input int half, input bit push, input int rst_at);
        if (push) begin
            q16.push_back({l, r});
            q15.push_back({l[15:1], r[15:1]});
        end
        send_slot(1'b0, l, nleft, half, -1);
        send_slot(1'b1, r, 32, half, rst_at);
    endtask

    initial begin
        int p0;
        reset = 1'b1;
        i2s_sclk = 1'b0;
        i2s_lrck = 1'b1;
        i2s_data = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_audio16", {a16_l, a16_r}, 32'd0);
        chk("reset_audio15", {2'b0, a15_l, a15_r}, 32'd0);
        chk("reset_sv", {30'd0, sv16, sv15}, 32'd0);
        chk("reset_ferr", {30'd0, fe16, fe15}, 32'd0);
        reset = 1'b0;

        // Right-slot preamble so the first left slot starts at a boundary
        send_slot(1'b1, 16'h0000, 32, H3, -1);

        // Basic pairs at 3.072 MHz; 0x7FFE/0x0003 also exercises the 15-bit instance
        send_frame(16'h1234, 16'hABCD, 32, H3, 1'b1, -1);
        send_frame(16'h7FFE, 16'h0003, 32, H3, 1'b1, -1);

        // Reset in the middle of a right slot drops that frame
        send_frame(16'h5555, 16'hAAAA, 32, H6, 1'b1, -1);
        send_frame(16'h0F0F, 16'hF0F0, 32, H6, 1'b0, 16);
        send_frame(16'h1111, 16'h2222, 32, H6, 1'b1, -1);

        // Streaming run: L = n, R = ~n
        for (int n = 0; n < 64; n++)
            send_frame(16'(n), ~16'(n), 32, H6, 1'b1, -1);

        // Short (20 sclk) left slot
        send_frame(16'hC3C3, 16'h3C3C, 32, H6, 1'b1, -1);
        send_frame(16'hBEEF, 16'hFACE, 20, H6, !FCHK, -1);
        send_frame(16'h600D, 16'hF00D, 32, H6, 1'b1, -1);

        // Start of the next left slot closes the last frame, then sclk stops
        send_slot(1'b0, 16'h0000, 2, H6, -1);
        i2s_sclk = 1'b0;
        repeat (50) @(negedge clk);
        p0 = npulse16;
        #100000;
        @(negedge clk);
        chk("hold_no_pulse", 32'(npulse16 - p0), 32'd0);
        chk("hold_audio16", {a16_l, a16_r}, 32'h600DF00D);
        chk("hold_audio15", {2'b0, a15_l, a15_r}, {2'b0, 15'h3006, 15'h7806});

        chk("missing16", 32'(q16.size()), 32'd0);
        chk("missing15", 32'(q15.size()), 32'd0);
        chk("ferr16_count", 32'(nferr16), FCHK ? 32'd1 : 32'd0);
        chk("ferr15_count", 32'(nferr15), FCHK ? 32'd1 : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
